// File: rtl/pacman_referee.sv
// Game referee for the Pac-Man maze: tracks IDLE/PLAY/WON/LOST, scores eaten
// candies from the bitmap popcount, enforces a play-time limit and gates moves.
module pacman_referee #(
  parameter int WIDTH     = 6,
  parameter int HEIGHT    = 6,
  parameter int SCORE_W   = 8,
  parameter int TICK_W    = 10,
  parameter int MAX_TICKS = 1000,
  localparam int CNT_W    = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [WIDTH-1:0][HEIGHT-1:0]   candies,
  input  logic                           catch,
  output logic [1:0]                     state,
  output logic                           move_en,
  output logic [SCORE_W-1:0]             score,
  output logic [CNT_W-1:0]               candies_left,
  output logic [TICK_W-1:0]              ticks,
  output logic                           timeout,
  output logic                           win_pulse,
  output logic                           lose_pulse
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_WON = 2'd2, S_LOST = 2'd3} state_t;

  // Sum is wide enough that score + delta can never wrap before saturation.
  localparam int SUM_W = ((SCORE_W > CNT_W+1) ? SCORE_W : CNT_W+1) + 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt, prev_left;
  logic [CNT_W:0]     diff;
  logic [SUM_W-1:0]   sum;
  logic [SCORE_W-1:0] score_sat;
  logic               clr_game, tick_inc, set_timeout;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < HEIGHT; j++)
        cnt = cnt + CNT_W'(candies[i][j]);
  end

  always_comb begin
    diff = {1'b0, prev_left} - {1'b0, cnt};
    sum  = SUM_W'(score) + SUM_W'(diff);
    if (sum > SUM_W'({SCORE_W{1'b1}})) score_sat = {SCORE_W{1'b1}};
    else                               score_sat = sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Win is judged on the live popcount so the post-reset zero in
  // candies_left can never look like an empty maze.
  always_comb begin
    state_d     = state_q;
    clr_game    = 1'b0;
    tick_inc    = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_PLAY;
        clr_game = 1'b1;
      end
      S_PLAY: begin
        if (catch)                                  state_d = S_LOST;
        else if (cnt == '0)                         state_d = S_WON;
        else if (ticks == TICK_W'(MAX_TICKS-1)) begin
          state_d     = S_LOST;
          set_timeout = 1'b1;
        end else                                    tick_inc = 1'b1;
      end
      default: if (start) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_left    <= '0;
      candies_left <= '0;
      score        <= '0;
      ticks        <= '0;
      timeout      <= 1'b0;
      win_pulse    <= 1'b0;
      lose_pulse   <= 1'b0;
    end else begin
      prev_left    <= cnt;
      candies_left <= cnt;
      win_pulse    <= (state_d == S_WON)  && (state_q != S_WON);
      lose_pulse   <= (state_d == S_LOST) && (state_q != S_LOST);
      if (clr_game) begin
        score   <= '0;
        ticks   <= '0;
        timeout <= 1'b0;
      end else begin
        if (state_q == S_PLAY && cnt < prev_left) score <= score_sat;
        if (tick_inc)    ticks   <= ticks + TICK_W'(1);
        if (set_timeout) timeout <= 1'b1;
      end
    end
  end

  assign state   = state_q;
  assign move_en = (state_q == S_PLAY);

endmodule

// File: tb/tb_pacman_referee.sv
// Directed bench for pacman_referee: default game, catch-vs-win race,
// mid-game reset, short timeout and narrow-score saturation instances.
module tb_pacman_referee;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] bits(input int n);
    return (36'd1 << n) - 36'd1;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // default instance
  logic d_start, d_catch;
  logic [5:0][5:0] d_candies;
  logic [1:0] d_state;
  logic d_move_en, d_timeout, d_win, d_lose;
  logic [7:0] d_score;
  logic [5:0] d_left;
  logic [9:0] d_ticks;

  pacman_referee u_dut (
    .clk(clk), .rst(rst), .start(d_start), .candies(d_candies), .catch(d_catch),
    .state(d_state), .move_en(d_move_en), .score(d_score), .candies_left(d_left),
    .ticks(d_ticks), .timeout(d_timeout), .win_pulse(d_win), .lose_pulse(d_lose)
  );

  // short time limit instance
  logic t_start, t_catch;
  logic [5:0][5:0] t_candies;
  logic [1:0] t_state;
  logic t_move_en, t_timeout, t_win, t_lose;
  logic [7:0] t_score;
  logic [5:0] t_left;
  logic [9:0] t_ticks;

  pacman_referee #(.MAX_TICKS(5)) u_dt (
    .clk(clk), .rst(rst), .start(t_start), .candies(t_candies), .catch(t_catch),
    .state(t_state), .move_en(t_move_en), .score(t_score), .candies_left(t_left),
    .ticks(t_ticks), .timeout(t_timeout), .win_pulse(t_win), .lose_pulse(t_lose)
  );

  // narrow score instance
  logic s_start, s_catch;
  logic [5:0][5:0] s_candies;
  logic [1:0] s_state;
  logic s_move_en, s_timeout, s_win, s_lose;
  logic [1:0] s_score;
  logic [5:0] s_left;
  logic [9:0] s_ticks;

  pacman_referee #(.SCORE_W(2)) u_ds (
    .clk(clk), .rst(rst), .start(s_start), .candies(s_candies), .catch(s_catch),
    .state(s_state), .move_en(s_move_en), .score(s_score), .candies_left(s_left),
    .ticks(s_ticks), .timeout(s_timeout), .win_pulse(s_win), .lose_pulse(s_lose)
  );

  initial begin
    rst = 1'b1;
    d_start = 0; d_catch = 0; d_candies = bits(20);
    t_start = 0; t_catch = 0; t_candies = bits(3);
    s_start = 0; s_catch = 0; s_candies = bits(6);
    step(); step();
    chk("rst_state", d_state, 0);
    chk("rst_move_en", d_move_en, 0);
    chk("rst_score", d_score, 0);
    chk("rst_left", d_left, 0);
    chk("rst_ticks", d_ticks, 0);
    chk("rst_timeout", d_timeout, 0);
    chk("rst_win", d_win, 0);
    chk("rst_lose", d_lose, 0);

    rst = 1'b0;
    step();
    chk("idle_left20", d_left, 20);
    chk("idle_state", d_state, 0);
    d_start = 1;
    step();
    chk("play_state", d_state, 1);
    chk("play_move_en", d_move_en, 1);
    d_start = 0;

    // three single-candy drops on distinct cycles
    d_candies = bits(20) ^ 36'h1;
    step(); chk("score1", d_score, 1);
    d_candies = bits(20) ^ 36'h3;
    step(); chk("score2", d_score, 2);
    d_candies = bits(20) ^ 36'h7;
    step(); chk("score3", d_score, 3);
    chk("left17", d_left, 17);
    chk("ticks3", d_ticks, 3);
    step(); chk("score_hold", d_score, 3);

    d_candies = '0;
    step();
    chk("won_state", d_state, 2);
    chk("won_pulse", d_win, 1);
    chk("won_score", d_score, 20);
    chk("won_move_en", d_move_en, 0);
    chk("won_lose", d_lose, 0);
    step();
    chk("won_pulse_drop", d_win, 0);
    chk("won_hold", d_state, 2);
    d_start = 1;
    step();
    chk("won_ack_idle", d_state, 0);
    chk("won_ack_score", d_score, 20);
    d_start = 0;

    // catch arrives with the last candy
    d_candies = bits(20);
    step();
    chk("refill_score", d_score, 20);
    d_start = 1;
    step();
    chk("g2_play", d_state, 1);
    chk("g2_score_clr", d_score, 0);
    d_start = 0;
    d_candies = bits(1);
    step(); chk("g2_score19", d_score, 19);
    d_candies = '0; d_catch = 1;
    step();
    chk("race_state", d_state, 3);
    chk("race_timeout", d_timeout, 0);
    chk("race_win", d_win, 0);
    chk("race_lose", d_lose, 1);
    chk("race_score", d_score, 20);
    step();
    chk("race_lose_drop", d_lose, 0);
    chk("race_win2", d_win, 0);
    chk("race_hold", d_state, 3);
    d_catch = 0; d_start = 1;
    step(); chk("lost_ack_idle", d_state, 0);
    d_start = 0;

    // reset in the middle of a game
    d_candies = bits(20); d_start = 1;
    step(); d_start = 0;
    d_candies = bits(19);
    step(); chk("mid_score1", d_score, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_state", d_state, 0);
    chk("mid_rst_move_en", d_move_en, 0);
    chk("mid_rst_score", d_score, 0);
    chk("mid_rst_left", d_left, 0);
    chk("mid_rst_ticks", d_ticks, 0);
    rst = 1'b0;
    step();

    // timeout with MAX_TICKS=5
    t_start = 1;
    step();
    chk("to_play", t_state, 1);
    chk("to_ticks0", t_ticks, 0);
    t_start = 0;
    repeat (4) step();
    chk("to_still_play", t_state, 1);
    chk("to_ticks4", t_ticks, 4);
    chk("to_not_yet", t_timeout, 0);
    step();
    chk("to_lost", t_state, 3);
    chk("to_flag", t_timeout, 1);
    chk("to_lose_pulse", t_lose, 1);
    chk("to_ticks_hold", t_ticks, 4);
    chk("to_move_en", t_move_en, 0);
    step();
    chk("to_ticks_hold2", t_ticks, 4);
    chk("to_lose_drop", t_lose, 0);
    chk("to_win", t_win, 0);
    chk("to_score", t_score, 0);
    chk("to_left", t_left, 3);

    // saturation with SCORE_W=2
    s_start = 1;
    step();
    chk("sat_play", s_state, 1);
    s_start = 0;
    s_candies = bits(4);
    step(); chk("sat_score2", s_score, 2);
    s_candies = bits(1);
    step();
    chk("sat_score3", s_score, 3);
    chk("sat_left1", s_left, 1);
    chk("sat_state", s_state, 1);
    chk("sat_move_en", s_move_en, 1);
    chk("sat_flags", {s_timeout, s_win, s_lose}, 0);
    chk("sat_ticks", s_ticks, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
